// File: rtl/aes_dec_round_pipe.sv
// One AES decryption round: AddRoundKey -> [InvMixColumns] -> InvShiftRows -> InvSubBytes,
// in a 1- or 2-stage valid/ready pipeline that carries a sideband tag with every block.
module aes_dec_round_pipe #(
  parameter int BLOCK_LENGTH = 128,
  parameter bit MIX_EN       = 1'b0,
  parameter int PIPE_STAGES  = 2,
  parameter int TAG_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  if (BLOCK_LENGTH != 128) begin : g_bad_length
    $error("aes_dec_round_pipe: BLOCK_LENGTH must be 128");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
    $error("aes_dec_round_pipe: PIPE_STAGES must be 1 or 2");
  end

  // NOTE: a constant table is pure logic with no storage, so there is nothing to reset.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x09/0x0b/0x0d/0x0e built from x, x^2 and x^3 multiples.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (c[3] ? b8 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      r[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      r[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      r[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return r;
  endfunction

  // Row r of the column-major state rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = INV_SBOX[s[127-8*k -: 8]];
    end
    return r;
  endfunction

  logic         en;
  logic         accept;
  logic [127:0] ark;
  logic [127:0] mixed;
  logic [127:0] shifted;

  // Single global advance: the whole pipe moves whenever the output slot can be refilled.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign ark      = IN ^ KEY;

  if (MIX_EN) begin : g_mix
    assign mixed = inv_mix_columns(ark);
  end else begin : g_no_mix
    assign mixed = ark;
  end

  assign shifted = inv_shift_rows(mixed);

  if (PIPE_STAGES == 1) begin : g_one_stage
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rst) begin
        out_valid <= 1'b0;
        OUT       <= '0;
        out_tag   <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= accept;
        OUT       <= inv_sub_bytes(shifted);
        out_tag   <= in_tag;
      end
    end

    assign busy = out_valid;
  end else begin : g_two_stage
    logic               s1_valid;
    logic [127:0]       s1_data;
    logic [TAG_W-1:0]   s1_tag;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_valid  <= 1'b0;
        s1_data   <= '0;
        s1_tag    <= '0;
        out_valid <= 1'b0;
        OUT       <= '0;
        out_tag   <= '0;
      end else if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (en) begin
        s1_valid  <= accept;
        s1_data   <= shifted;
        s1_tag    <= in_tag;
        out_valid <= s1_valid;
        OUT       <= inv_sub_bytes(s1_data);
        out_tag   <= s1_tag;
      end
    end

    assign busy = s1_valid | out_valid;
  end

endmodule
